xpb_rom_arbiter: RTL

//   Shares one registered xpb lookup ROM (5-bit index -> 1024-bit precomputed

---
 rtl/xpb_rom_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/xpb_rom_arbiter.sv
// Round-robin arbiter sharing one registered xpb lookup ROM among NREQ
// requesters. Each result returns tagged with the ID of the requester that
// issued it. A flush or reset drops every lookup still in flight.
module xpb_rom_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDXW    = 5,
    parameter int unsigned DATAW   = 1024,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*IDXW-1:0]    req_idx,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    flush,
    output logic [IDXW-1:0]         rom_idx,
    input  logic [DATAW-1:0]        rom_data,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [DATAW-1:0]        rsp_data,
    output logic                    busy
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0]     rr_ptr_q;
    logic [ROM_LAT-1:0] tag_valid_q;
    logic [IDW-1:0]     tag_id_q [ROM_LAT];

    logic               gnt_found;
    logic [IDW-1:0]     gnt_id;
    logic [NREQ-1:0]    gnt_vec;
    logic               grant;

    // (base + step) mod NREQ; keeps the pointer inside 0..NREQ-1 when NREQ
    // is not a power of two.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base,
                                                input int unsigned    step);
        int unsigned s;
        s = 32'(base) + step;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return s[IDW-1:0];
    endfunction

    // Scan requesters from rr_ptr upward; the first valid one wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_vec   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[wrap_inc(rr_ptr_q, k)]) begin
                gnt_found                    = 1'b1;
                gnt_id                       = wrap_inc(rr_ptr_q, k);
                gnt_vec[wrap_inc(rr_ptr_q, k)] = 1'b1;
            end
        end
    end

    // Grants are suppressed during flush and reset; the ROM sees index 0 when idle.
    always_comb begin
        grant     = gnt_found & rst_n & ~flush;
        req_ready = grant ? gnt_vec : '0;
        rom_idx   = grant ? req_idx[32'(gnt_id) * IDXW +: IDXW] : '0;
        busy      = (|tag_valid_q) | rsp_valid;
    end

    // Pointer, tag pipeline aligned with ROM latency, and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            tag_valid_q <= '0;
            for (int unsigned s = 0; s < ROM_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
        end else begin
            if (grant) begin
                rr_ptr_q <= wrap_inc(gnt_id, 1);
            end
            // grant is already low during flush, so stage 0 takes a bubble.
            tag_valid_q[0] <= grant;
            tag_id_q[0]    <= gnt_id;
            for (int unsigned s = 1; s < ROM_LAT; s++) begin
                tag_valid_q[s] <= tag_valid_q[s-1] & ~flush;
                tag_id_q[s]    <= tag_id_q[s-1];
            end
            // A tag reaching the last stage together with flush is dropped.
            if (tag_valid_q[ROM_LAT-1] && !flush) begin
                rsp_valid <= 1'b1;
                rsp_id    <= tag_id_q[ROM_LAT-1];
                rsp_data  <= rom_data;
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
